// File: rtl/fifo_pkg.sv
// Shared constants and width helper for the synchronous FIFO slice.
// Pure compile-time content: no latency, no flow control.
package fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  // Bits needed to encode values 0..n-1, never less than one bit.
  function automatic int fifo_bits(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// DATA_WIDTH x DEPTH storage: synchronous write, combinational read by address.
// Zero-cycle read path; no flow control, the caller guarantees valid addresses.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AW         = fifo_bits(DEPTH)
) (
  input  logic                  clk,
  input  logic                  i_wr_en,
  input  logic [AW-1:0]         i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic [AW-1:0]         i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO with count, almost flags, sticky errors; standard (1-cycle) or FWFT read.
// Writes refused while full, reads refused while empty; each refusal sets a sticky error bit.
module fifo_sync_flags
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int DEPTH         = 16,
  parameter int FWFT          = FIFO_MODE_STD,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 2,
  localparam int CW           = fifo_bits(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [CW-1:0]         count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam int            PW       = fifo_bits(DEPTH);
  localparam bit            IS_FWFT  = (FWFT == FIFO_MODE_FWFT);
  localparam logic [CW-1:0] C_DEPTH  = CW'(DEPTH);
  localparam logic [CW-1:0] C_AFULL  = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] C_AEMPTY = CW'(AEMPTY_THRESH);
  localparam logic [PW-1:0] P_LAST   = PW'(DEPTH - 1);

  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_rd_valid;
  logic                  r_head_vld;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic [CW-1:0]         w_mem_cnt;
  logic                  w_mem_empty;
  logic                  w_head_from_wr;
  logic                  w_mem_wr;
  logic                  w_mem_rd;
  logic [DATA_WIDTH-1:0] w_ram_rd_data;

  // Explicit wrap so non-power-of-two depths never alias.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == P_LAST) ? '0 : p + PW'(1);
  endfunction

  assign w_full   = (r_count == C_DEPTH);
  assign w_empty  = IS_FWFT ? !r_head_vld : (r_count == '0);
  assign w_wr_acc = wr_en & !w_full;
  assign w_rd_acc = rd_en & !w_empty;

  // In FWFT the head register holds one of the counted words; the rest live in RAM.
  // A write bypasses RAM into the head whenever the head would otherwise be empty.
  always_comb begin
    w_mem_cnt      = r_count - CW'(r_head_vld);
    w_mem_empty    = (w_mem_cnt == '0);
    w_head_from_wr = 1'b0;
    w_mem_wr       = w_wr_acc;
    w_mem_rd       = w_rd_acc;
    if (IS_FWFT) begin
      w_head_from_wr = w_wr_acc & (!r_head_vld | (w_rd_acc & w_mem_empty));
      w_mem_wr       = w_wr_acc & !w_head_from_wr;
      w_mem_rd       = w_rd_acc & !w_mem_empty;
    end
  end

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (PW)
  ) u_ram (
    .clk        (clk),
    .i_wr_en    (w_mem_wr),
    .i_wr_addr  (r_wr_ptr),
    .i_wr_data  (wr_data),
    .i_rd_addr  (r_rd_ptr),
    .o_rd_data  (w_ram_rd_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_mem_wr) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_mem_rd) r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_head_vld <= 1'b0;
    end else if (IS_FWFT) begin
      r_rd_valid <= 1'b0;
      if (w_head_from_wr) begin
        r_rd_data  <= wr_data;
        r_head_vld <= 1'b1;
      end else if (w_mem_rd) begin
        r_rd_data  <= w_ram_rd_data;
      end else if (w_rd_acc) begin
        r_head_vld <= 1'b0;
      end
    end else begin
      r_head_vld <= 1'b0;
      r_rd_valid <= w_rd_acc;
      if (w_rd_acc) r_rd_data <= w_ram_rd_data;
    end
  end

  // A fresh error outranks a clear arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (wr_en & w_full)      r_overflow <= 1'b1;
      else if (clr_err)        r_overflow <= 1'b0;
      if (rd_en & w_empty)     r_underflow <= 1'b1;
      else if (clr_err)        r_underflow <= 1'b0;
    end
  end

  assign rd_data      = r_rd_data;
  assign rd_valid     = IS_FWFT ? r_head_vld : r_rd_valid;
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= C_AFULL);
  assign almost_empty = (r_count <= C_AEMPTY);
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Directed bench: standard DEPTH=16, FWFT DEPTH=4 and standard DEPTH=5 instances share stimulus.
module tb_fifo_sync_flags;
  import fifo_pkg::*;

  logic       clk = 1'b0;
  logic       reset, wr_en, rd_en, clr_err;
  logic [7:0] wr_data;

  logic [7:0] s_rd_data, f_rd_data, d_rd_data;
  logic       s_rd_valid, f_rd_valid, d_rd_valid;
  logic       s_full, f_full, d_full, s_empty, f_empty, d_empty;
  logic       s_af, f_af, d_af, s_ae, f_ae, d_ae;
  logic       s_ovf, f_ovf, d_ovf, s_unf, f_unf, d_unf;
  logic [4:0] s_count;
  logic [2:0] f_count, d_count;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  fifo_sync_flags #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(FIFO_MODE_STD)) u_std (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(s_rd_data), .rd_valid(s_rd_valid), .full(s_full), .empty(s_empty),
    .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
    .overflow(s_ovf), .underflow(s_unf), .clr_err(clr_err));

  fifo_sync_flags #(.DATA_WIDTH(8), .DEPTH(4), .FWFT(FIFO_MODE_FWFT)) u_fw (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(f_rd_data), .rd_valid(f_rd_valid), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
    .overflow(f_ovf), .underflow(f_unf), .clr_err(clr_err));

  fifo_sync_flags #(.DATA_WIDTH(8), .DEPTH(5), .FWFT(FIFO_MODE_STD)) u_d5 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(d_rd_data), .rd_valid(d_rd_valid), .full(d_full), .empty(d_empty),
    .almost_full(d_af), .almost_empty(d_ae), .count(d_count),
    .overflow(d_ovf), .underflow(d_unf), .clr_err(clr_err));

  typedef struct {
    int wr; int wd; int rd; int clr;
    int cnt; int emp; int ful; int af; int ae; int rv; int rdd; int ovf; int unf;
  } vec_t;

  vec_t       tbl [13];
  logic [7:0] q [$];
  logic [7:0] exp_b;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; wr_data = 8'h00;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic check_std(input string tag, input int cnt, input int emp, input int ful,
                           input int af, input int ae, input int rv, input int rdd,
                           input int ovf, input int unf);
    chk({tag, ".count"}, 32'(s_count), cnt);
    chk({tag, ".empty"}, 32'(s_empty), emp);
    chk({tag, ".full"}, 32'(s_full), ful);
    chk({tag, ".afull"}, 32'(s_af), af);
    chk({tag, ".aempty"}, 32'(s_ae), ae);
    chk({tag, ".rd_valid"}, 32'(s_rd_valid), rv);
    chk({tag, ".rd_data"}, 32'(s_rd_data), rdd);
    chk({tag, ".overflow"}, 32'(s_ovf), ovf);
    chk({tag, ".underflow"}, 32'(s_unf), unf);
  endtask

  initial begin
    // wr wd rd clr | cnt emp ful af ae rv rdd ovf unf  (DEPTH=16, AF=14, AE=2)
    tbl[0]  = '{0, 'h00, 0, 0,  0, 1, 0, 0, 1, 0, 'h00, 0, 0};
    tbl[1]  = '{0, 'h00, 1, 0,  0, 1, 0, 0, 1, 0, 'h00, 0, 1};
    tbl[2]  = '{1, 'hAA, 1, 0,  1, 0, 0, 0, 1, 0, 'h00, 0, 1};
    tbl[3]  = '{0, 'h00, 0, 1,  1, 0, 0, 0, 1, 0, 'h00, 0, 0};
    tbl[4]  = '{1, 'h55, 0, 0,  2, 0, 0, 0, 1, 0, 'h00, 0, 0};
    tbl[5]  = '{1, 'h66, 0, 0,  3, 0, 0, 0, 0, 0, 'h00, 0, 0};
    tbl[6]  = '{0, 'h00, 1, 0,  2, 0, 0, 0, 1, 1, 'hAA, 0, 0};
    tbl[7]  = '{0, 'h00, 0, 0,  2, 0, 0, 0, 1, 0, 'hAA, 0, 0};
    tbl[8]  = '{1, 'h77, 1, 0,  2, 0, 0, 0, 1, 1, 'h55, 0, 0};
    tbl[9]  = '{0, 'h00, 1, 0,  1, 0, 0, 0, 1, 1, 'h66, 0, 0};
    tbl[10] = '{0, 'h00, 1, 0,  0, 1, 0, 0, 1, 1, 'h77, 0, 0};
    tbl[11] = '{0, 'h00, 1, 1,  0, 1, 0, 0, 1, 0, 'h77, 0, 1};
    tbl[12] = '{0, 'h00, 0, 1,  0, 1, 0, 0, 1, 0, 'h77, 0, 0};

    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    // Directed table on the standard DEPTH=16 instance
    for (int i = 0; i < 13; i++) begin
      wr_en = tbl[i].wr[0]; wr_data = tbl[i].wd[7:0];
      rd_en = tbl[i].rd[0]; clr_err = tbl[i].clr[0];
      tick();
      check_std($sformatf("tbl%0d", i), tbl[i].cnt, tbl[i].emp, tbl[i].ful, tbl[i].af,
                tbl[i].ae, tbl[i].rv, tbl[i].rdd, tbl[i].ovf, tbl[i].unf);
    end

    // Fill to full, overflow, drain in order
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      wr_en = 1'b1; wr_data = 8'(k);
      tick();
      check_std($sformatf("fill%0d", k), k, 0, (k == 16) ? 1 : 0, (k >= 14) ? 1 : 0,
                (k <= 2) ? 1 : 0, 0, 0, 0, 0);
    end
    wr_data = 8'h11;
    tick();
    wr_en = 1'b0;
    check_std("overflow17", 16, 0, 1, 1, 0, 0, 0, 1, 0);
    for (int k = 1; k <= 16; k++) begin
      rd_en = 1'b1;
      tick();
      chk($sformatf("drain%0d.rd_data", k), 32'(s_rd_data), k);
      chk($sformatf("drain%0d.rd_valid", k), 32'(s_rd_valid), 1);
      chk($sformatf("drain%0d.count", k), 32'(s_count), 16 - k);
    end
    rd_en = 1'b0;
    tick();
    check_std("drained", 0, 1, 0, 0, 1, 0, 16, 1, 0);

    // Simultaneous read/write at count=5 across pointer wrap
    do_reset();
    q.delete();
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h20 + i); q.push_back(wr_data);
      tick();
    end
    for (int i = 0; i < 20; i++) begin
      wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'(8'h40 + i); q.push_back(wr_data);
      tick();
      exp_b = q.pop_front();
      chk($sformatf("rw%0d.rd_data", i), 32'(s_rd_data), 32'(exp_b));
      chk($sformatf("rw%0d.count", i), 32'(s_count), 5);
      chk($sformatf("rw%0d.rd_valid", i), 32'(s_rd_valid), 1);
    end
    idle_inputs();

    // Reset mid-operation dominates a concurrent write
    do_reset();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h60 + i);
      tick();
    end
    wr_en = 1'b0; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check_std("pre_reset", 9, 0, 0, 0, 0, 1, 'h60, 0, 1);
    reset = 1'b1; wr_en = 1'b1; wr_data = 8'hFF;
    tick();
    reset = 1'b0; wr_en = 1'b0;
    check_std("mid_reset", 0, 1, 0, 0, 1, 0, 0, 0, 0);

    // FWFT instance, DEPTH=4
    do_reset();
    chk("fw_rst.empty", 32'(f_empty), 1);
    chk("fw_rst.rd_valid", 32'(f_rd_valid), 0);
    wr_en = 1'b1; wr_data = 8'h3C;
    tick();
    chk("fw_w1.empty", 32'(f_empty), 0);
    chk("fw_w1.rd_data", 32'(f_rd_data), 'h3C);
    chk("fw_w1.count", 32'(f_count), 1);
    chk("fw_w1.rd_valid", 32'(f_rd_valid), 1);
    wr_data = 8'h3D;
    tick();
    chk("fw_w2.rd_data", 32'(f_rd_data), 'h3C);
    chk("fw_w2.count", 32'(f_count), 2);
    wr_en = 1'b0; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("fw_r1.rd_data", 32'(f_rd_data), 'h3D);
    chk("fw_r1.count", 32'(f_count), 1);
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h3E + i);
      tick();
    end
    chk("fw_full.full", 32'(f_full), 1);
    chk("fw_full.count", 32'(f_count), 4);
    chk("fw_full.rd_data", 32'(f_rd_data), 'h3D);
    wr_data = 8'h41;
    tick();
    wr_en = 1'b0;
    chk("fw_ovf.overflow", 32'(f_ovf), 1);
    chk("fw_ovf.count", 32'(f_count), 4);
    rd_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("fw_drain%0d.rd_data", i), 32'(f_rd_data), 32'(8'h3E + i));
      chk($sformatf("fw_drain%0d.count", i), 32'(f_count), 3 - i);
    end
    tick();
    rd_en = 1'b0;
    chk("fw_empty.empty", 32'(f_empty), 1);
    chk("fw_empty.rd_valid", 32'(f_rd_valid), 0);
    chk("fw_empty.count", 32'(f_count), 0);
    wr_en = 1'b1; wr_data = 8'h50;
    tick();
    chk("fw_b1.rd_data", 32'(f_rd_data), 'h50);
    rd_en = 1'b1; wr_data = 8'h51;
    tick();
    chk("fw_b2.rd_data", 32'(f_rd_data), 'h51);
    chk("fw_b2.count", 32'(f_count), 1);
    chk("fw_b2.empty", 32'(f_empty), 0);
    wr_en = 1'b0;
    tick();
    chk("fw_b3.empty", 32'(f_empty), 1);
    chk("fw_b3.underflow", 32'(f_unf), 0);
    tick();
    rd_en = 1'b0;
    chk("fw_unf.underflow", 32'(f_unf), 1);

    // DEPTH=5: offset pointers, then fill/drain three times
    do_reset();
    wr_en = 1'b1; wr_data = 8'hEE;
    tick();
    wr_en = 1'b0; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 5; i++) begin
        wr_en = 1'b1; wr_data = 8'(r * 16 + i + 1);
        tick();
        chk($sformatf("d5_r%0d_w%0d.count", r, i), 32'(d_count), i + 1);
        chk($sformatf("d5_r%0d_w%0d.full", r, i), 32'(d_full), (i == 4) ? 1 : 0);
      end
      wr_en = 1'b0;
      for (int i = 0; i < 5; i++) begin
        rd_en = 1'b1;
        tick();
        chk($sformatf("d5_r%0d_r%0d.rd_data", r, i), 32'(d_rd_data), r * 16 + i + 1);
      end
      rd_en = 1'b0;
      chk($sformatf("d5_r%0d.empty", r), 32'(d_empty), 1);
    end
    chk("d5.overflow", 32'(d_ovf), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
